// File: rtl/cmp_seq.sv
// cmp_seq: multi-cycle EQ/NE/SLT/ULT comparator, walking CHUNK bits per cycle from the MSB chunk down.
// Define CMP_EARLY_EXIT_EN to finish at the first differing chunk instead of always taking NCHUNK cycles.
module cmp_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Z,
  output logic             eq
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] SIGN_BIT = WIDTH'(1) << (WIDTH - 1);

  localparam logic [1:0] OP_EQ  = 2'd0;
  localparam logic [1:0] OP_NE  = 2'd1;
  localparam logic [1:0] OP_SLT = 2'd2;
  localparam logic [1:0] OP_ULT = 2'd3;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  x_q, x_d, y_q, y_d;
  logic [1:0]        op_q, op_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              eq_acc_q, eq_acc_d;
  logic              lt_acc_q, lt_acc_d;
  logic              decided_q, decided_d;

  logic [WIDTH-1:0]  xm, ym;
  logic [CHUNK-1:0]  chunkX, chunkY;
  logic              chunkDiff;

  // Flipping the sign bit on both operands turns a signed compare into an unsigned one;
  // only the MSB chunk ever sees that bit, so the flip can be applied to the whole word.
  always_comb begin
    xm        = x_q ^ ((op_q == OP_SLT) ? SIGN_BIT : '0);
    ym        = y_q ^ ((op_q == OP_SLT) ? SIGN_BIT : '0);
    chunkX    = xm[idx_q*CHUNK +: CHUNK];
    chunkY    = ym[idx_q*CHUNK +: CHUNK];
    chunkDiff = (chunkX != chunkY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      op_q      <= '0;
      idx_q     <= '0;
      eq_acc_q  <= 1'b0;
      lt_acc_q  <= 1'b0;
      decided_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      eq_acc_q  <= eq_acc_d;
      lt_acc_q  <= lt_acc_d;
      decided_q <= decided_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = BUSY;
      BUSY: begin
        if (idx_q == '0) state_d = DONE;
`ifdef CMP_EARLY_EXIT_EN
        else if (!decided_q && chunkDiff) state_d = DONE;
`endif
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The first differing chunk from the top decides the ordering; later chunks are ignored.
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    op_d      = op_q;
    idx_d     = idx_q;
    eq_acc_d  = eq_acc_q;
    lt_acc_d  = lt_acc_q;
    decided_d = decided_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d       = X;
          y_d       = Y;
          op_d      = op;
          idx_d     = LAST_IDX;
          eq_acc_d  = 1'b1;
          lt_acc_d  = 1'b0;
          decided_d = 1'b0;
        end
      end
      BUSY: begin
        if (!decided_q && chunkDiff) begin
          decided_d = 1'b1;
          eq_acc_d  = 1'b0;
          lt_acc_d  = (chunkX < chunkY);
        end
        if (idx_q != '0) idx_d = idx_q - IDXW'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    eq        = out_valid & eq_acc_q;
    Z         = 1'b0;
    if (out_valid) begin
      case (op_q)
        OP_EQ:   Z = eq_acc_q;
        OP_NE:   Z = ~eq_acc_q;
        default: Z = lt_acc_q;
      endcase
    end
  end

endmodule
